rr_mux16_arbiter: RTL and testbench
===================================

RR_MUX16_ARBITER -- requirements
Module: rr_mux16_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive beats one locked requester may hold the shared mux (legal range 1..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req  in  16  per-requester request; bit i = requester i has a data bit pending.
REQ-005 lock  in  16  per-requester burst request; sampled with req.
REQ-006 din  in  16  per-requester data bit; din[i] valid while req[i]=1.
REQ-007 out_ready  in  1  downstream accepts out_data when out_valid=1.
REQ-008 gnt  out  16  one-hot, single-cycle pulse: din[i] captured on this edge.
REQ-009 out_valid  out  1  out_data/out_id hold a valid beat.
REQ-010 out_data  out  1  selected data bit, registered.
REQ-011 out_id  out  4  index of requester that produced out_data.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 Slot free = (!out_valid || out_ready); capture happens only on an edge where slot free and a winner exists.
REQ-014 Winner: first i with req[i]=1 searching ptr, ptr+1, ... wrapping 15->0; ptr resets to 0.
REQ-015 Data path: sel=winner drives the MUX16 instance; out_data<=MUX16 output, out_id<=winner, out_valid<=1, gnt<=onehot(winner); latency 1 cycle req->out_valid.
REQ-016 On capture, ptr<=(winner+1) mod 16 (4-bit wrap), except while in LOCK, where ptr is held.
REQ-017 Slot free and no winner: out_valid<=0, gnt<=0.
REQ-018 Stall (out_valid=1, out_ready=0): out_data, out_id, out_valid, ptr, burst count, state hold; gnt<=0; req/din changes ignored.
REQ-019 States: IDLE (out_valid=0), RUN (normal round robin), LOCK (owner fixed).
REQ-020 IDLE->RUN on capture of a winner with lock=0; IDLE/RUN->LOCK on capture of a winner with lock=1, cnt<=1, owner<=winner.
REQ-021 In LOCK with slot free: if req[owner]&&lock[owner]&&cnt<MAX_BURST, owner wins regardless of ptr, cnt<=cnt+1; else exit to RUN (or IDLE if no req) and arbitrate normally in that same cycle, cnt<=0.
REQ-022 After a burst ends, owner cannot win before ptr passes it (ptr=owner+1 already set).
REQ-023 RUN->IDLE when slot free and req=0.
REQ-024 MAX_BURST=1 makes lock equivalent to no-lock for fairness.
REQ-025 gnt is one-hot or zero every cycle; never asserted on a stall cycle.

Reset
REQ-026 rst_n=0 at an edge: state=IDLE, ptr=0, cnt=0, gnt=0, out_valid=0, out_data=0, out_id=0, busy=0, regardless of stall or LOCK in progress.
REQ-027 First capture possible on the first edge with rst_n=1.

Structure
REQ-028 Shared package mux_arb_pkg: N_REQ=16, ID_W=4, state enum {IDLE,RUN,LOCK}.
REQ-029 One sub-module: existing MUX16 instantiated once for data selection; priority search and FSM in this module.

Verification
REQ-030 req=16'h0005, din=16'h0004, out_ready=1 after reset -> gnt 0001 then 0004, out_id 0 then 2, out_data 0 then 1, ptr 1 then 3.
REQ-031 req=16'hFFFF held, out_ready=1 for 17 cycles -> out_id 0,1,...,15,0; each gnt bit pulses once per 16 cycles.
REQ-032 req=16'h0009, lock=16'h0001, MAX_BURST=4 -> out_id 0,0,0,0,3,0,0,0,0,3...
REQ-033 Beat valid, out_ready=0 for 3 cycles with req toggling -> out_data/out_id stable, gnt=0 for 3 cycles, next beat on the cycle after out_ready=1.
REQ-034 rst_n=0 for one edge mid-LOCK with stall active -> next cycle all outputs 0, state IDLE; subsequent req=16'h8000 -> out_id 15, ptr wraps to 0.
REQ-035 Assertion throughout: $onehot0(gnt); out_valid=0 in IDLE.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 16-way round-robin mux arbiter.
// Holds the requester count, id width, arbiter state encoding and a one-hot helper.
package mux_arb_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/mux16.sv
// 16:1 single-bit data mux; the arbiter's winner index drives the select.
module mux16
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_data,
    input  logic [ID_W-1:0]  i_sel,
    output logic             o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter over 16 single-bit requesters with optional locked bursts,
// feeding one registered output slot through a shared MUX16.
module rr_mux16_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic [N_REQ-1:0] din,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic             out_valid,
    output logic             out_data,
    output logic [ID_W-1:0]  out_id,
    output logic             busy,
    output arb_state_e       o_dbg_state,
    output logic [ID_W-1:0]  o_dbg_ptr,
    output logic [3:0]       o_dbg_cnt
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    arb_state_e       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic             r_out_valid, w_valid_nxt;
    logic             r_out_data, w_data_nxt;
    logic [ID_W-1:0]  r_out_id, w_id_nxt;

    logic             w_slot_free;
    logic             w_lock_cont;
    logic             w_rr_found;
    logic [ID_W-1:0]  w_rr_win;
    logic [ID_W-1:0]  w_idx;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic             w_mux_out;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_lock_cont = (r_state == LOCK) && req[r_owner] && lock[r_owner] && (r_cnt < MAX_B);

    // First requester at or after ptr, wrapping 15 -> 0.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = r_ptr + ID_W'(k);
            if (!w_rr_found && req[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx;
            end
        end
    end

    assign w_found = w_lock_cont || w_rr_found;
    assign w_win   = w_lock_cont ? r_owner : w_rr_win;

    mux16 u_mux16 (
        .i_data (din),
        .i_sel  (w_win),
        .o_data (w_mux_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = '0;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        w_id_nxt    = r_out_id;
        if (w_slot_free) begin
            if (w_found) begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_mux_out;
                w_id_nxt    = w_win;
                w_gnt_nxt   = onehot(w_win);
                if (w_lock_cont) begin
                    // Burst continues: ptr stays put so the owner cannot starve others later.
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_ptr_nxt = w_win + ID_W'(1);
                    if (lock[w_win]) begin
                        w_state_nxt = LOCK;
                        w_cnt_nxt   = 4'd1;
                        w_owner_nxt = w_win;
                    end else begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 4'd0;
                    end
                end
            end else begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_id    <= w_id_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_id      = r_out_id;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;
    assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// Directed bench for rr_mux16_arbiter: reset, round robin, locked bursts,
// stalls and reset during a stalled burst, plus per-cycle grant invariants.
module tb_rr_mux16_arbiter;
    import mux_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] lock;
    logic [15:0] din;
    logic        out_ready;
    logic [15:0] gnt;
    logic        out_valid;
    logic        out_data;
    logic [3:0]  out_id;
    logic        busy;
    arb_state_e  dbg_state;
    logic [3:0]  dbg_ptr;
    logic [3:0]  dbg_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rr_mux16_arbiter #(.MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lock        (lock),
        .din         (din),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_id      (out_id),
        .busy        (busy),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr),
        .o_dbg_cnt   (dbg_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        lock      = '0;
        din       = '0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Grant invariants checked every cycle out of reset.
    logic r_prev_stall = 1'b0;
    always @(posedge clk) r_prev_stall <= (rst_n === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b0);

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            if (!$onehot0(gnt) || (r_prev_stall && gnt !== 16'h0)) $display("FAIL monitor_gnt gnt=%h prev_stall=%0b", gnt, r_prev_stall);
            else n_pass++;
            n_checks++;
            if (dbg_state == IDLE && out_valid !== 1'b0) $display("FAIL monitor_idle_valid out_valid=%0b in IDLE", out_valid);
            else n_pass++;
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 16'hFFFF;
        lock      = 16'hFFFF;
        din       = 16'hFFFF;
        out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if ({gnt, out_valid, out_data, out_id, busy, dbg_ptr, dbg_cnt} !== 43'h0)
            $display("FAIL reset_outputs gnt=%h v=%0b d=%0b id=%0d busy=%0b ptr=%0d cnt=%0d required all 0",
                     gnt, out_valid, out_data, out_id, busy, dbg_ptr, dbg_cnt);
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_gnt [3] = '{16'h0001, 16'h0004, 16'h0001};
        logic [3:0]  exp_id  [3] = '{4'd0, 4'd2, 4'd0};
        logic        exp_dat [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0]  exp_ptr [3] = '{4'd1, 4'd3, 4'd1};
        do_reset();
        req = 16'h0005;
        din = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (gnt !== exp_gnt[i] || out_id !== exp_id[i])
                $display("FAIL basic_gnt_id[%0d] gnt=%h id=%0d required gnt=%h id=%0d", i, gnt, out_id, exp_gnt[i], exp_id[i]);
            else n_pass++;
            n_checks++;
            if (out_data !== exp_dat[i] || out_valid !== 1'b1 || dbg_ptr !== exp_ptr[i] || dbg_state !== RUN)
                $display("FAIL basic_data_ptr[%0d] d=%0b v=%0b ptr=%0d st=%0d required d=%0b v=1 ptr=%0d st=RUN",
                         i, out_data, out_valid, dbg_ptr, dbg_state, exp_dat[i], exp_ptr[i]);
            else n_pass++;
        end
        req = 16'h0000;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || gnt !== 16'h0 || dbg_state !== IDLE || busy !== 1'b0)
            $display("FAIL basic_to_idle v=%0b gnt=%h st=%0d busy=%0b required v=0 gnt=0 st=IDLE busy=0",
                     out_valid, gnt, dbg_state, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int          pulses [16];
        logic [15:0] eg;
        int          e;
        do_reset();
        din = 16'hA5C3;
        req = 16'hFFFF;
        for (int b = 0; b < 16; b++) pulses[b] = 0;
        for (int k = 0; k < 17; k++) begin
            step();
            e  = k % 16;
            eg = 16'h0001 << e;
            n_checks++;
            if (out_id !== 4'(e) || gnt !== eg || out_data !== din[e])
                $display("FAIL rr_beat[%0d] id=%0d gnt=%h d=%0b required id=%0d gnt=%h d=%0b",
                         k, out_id, gnt, out_data, e, eg, din[e]);
            else n_pass++;
            if (k < 16) for (int b = 0; b < 16; b++) pulses[b] += int'(gnt[b]);
        end
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (pulses[b] != 1) $display("FAIL rr_pulses[%0d] got=%0d required=1", b, pulses[b]);
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_ids [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
        do_reset();
        req  = 16'h0009;
        lock = 16'h0001;
        din  = 16'h0008;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (out_id !== exp_ids[i] || out_data !== din[exp_ids[i]] || out_valid !== 1'b1)
                $display("FAIL lock_beat[%0d] id=%0d d=%0b v=%0b required id=%0d d=%0b v=1",
                         i, out_id, out_data, out_valid, exp_ids[i], din[exp_ids[i]]);
            else n_pass++;
            if (i == 0 || i == 3 || i == 5) begin
                n_checks++;
                if (dbg_state !== LOCK || dbg_cnt !== ((i == 3) ? 4'd4 : 4'd1) || dbg_ptr !== 4'd1)
                    $display("FAIL lock_state[%0d] st=%0d cnt=%0d ptr=%0d required st=LOCK cnt=%0d ptr=1",
                             i, dbg_state, dbg_cnt, dbg_ptr, (i == 3) ? 4 : 1);
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (dbg_state !== RUN || dbg_cnt !== 4'd0 || dbg_ptr !== 4'd4)
                    $display("FAIL lock_exit st=%0d cnt=%0d ptr=%0d required st=RUN cnt=0 ptr=4", dbg_state, dbg_cnt, dbg_ptr);
                else n_pass++;
            end
        end
        lock = '0;
    endtask

    task automatic test_stall();
        logic [15:0] stall_req [3] = '{16'hFFFC, 16'h0000, 16'h00F0};
        do_reset();
        req = 16'h0003;
        din = 16'h0002;
        step();
        n_checks++;
        if (out_id !== 4'd0 || out_data !== 1'b0 || out_valid !== 1'b1 || gnt !== 16'h0001)
            $display("FAIL stall_first id=%0d d=%0b v=%0b gnt=%h required id=0 d=0 v=1 gnt=0001", out_id, out_data, out_valid, gnt);
        else n_pass++;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = stall_req[i];
            din = ~din;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 4'd0 || out_data !== 1'b0 || gnt !== 16'h0 || dbg_ptr !== 4'd1)
                $display("FAIL stall_hold[%0d] v=%0b id=%0d d=%0b gnt=%h ptr=%0d required v=1 id=0 d=0 gnt=0 ptr=1",
                         i, out_valid, out_id, out_data, gnt, dbg_ptr);
            else n_pass++;
        end
        out_ready = 1'b1;
        req       = 16'h0003;
        din       = 16'h0002;
        step();
        n_checks++;
        if (out_id !== 4'd1 || out_data !== 1'b1 || gnt !== 16'h0002 || dbg_ptr !== 4'd2)
            $display("FAIL stall_release id=%0d d=%0b gnt=%h ptr=%0d required id=1 d=1 gnt=0002 ptr=2",
                     out_id, out_data, gnt, dbg_ptr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req  = 16'h0001;
        lock = 16'h0001;
        din  = 16'h0001;
        step();
        step();
        out_ready = 1'b0;
        step();
        n_checks++;
        if (dbg_state !== LOCK || dbg_cnt !== 4'd2 || gnt !== 16'h0 || out_valid !== 1'b1)
            $display("FAIL midlock_stall st=%0d cnt=%0d gnt=%h v=%0b required st=LOCK cnt=2 gnt=0 v=1",
                     dbg_state, dbg_cnt, gnt, out_valid);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({gnt, out_valid, out_data, out_id, busy, dbg_ptr, dbg_cnt} !== 43'h0 || dbg_state !== IDLE)
            $display("FAIL midlock_reset gnt=%h v=%0b d=%0b id=%0d busy=%0b ptr=%0d cnt=%0d st=%0d required all 0 st=IDLE",
                     gnt, out_valid, out_data, out_id, busy, dbg_ptr, dbg_cnt, dbg_state);
        else n_pass++;
        rst_n     = 1'b1;
        req       = 16'h8000;
        lock      = 16'h0000;
        din       = 16'h8000;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_id !== 4'd15 || gnt !== 16'h8000 || out_data !== 1'b1 || dbg_ptr !== 4'd0 || dbg_state !== RUN)
            $display("FAIL midlock_wrap id=%0d gnt=%h d=%0b ptr=%0d st=%0d required id=15 gnt=8000 d=1 ptr=0 st=RUN",
                     out_id, gnt, out_data, dbg_ptr, dbg_state);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        lock      = '0;
        din       = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_round_robin();
        test_lock();
        test_stall();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
